// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: FIFO-buffered 8N1 UART transmitter.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
module uart_tx_serializer #(
  parameter int CLK_DIV    = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int FIFO_AW    = 3
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [7:0]         in_data,
  output logic               in_ready,
  output logic               tx,
  output logic               busy,
  output logic [FIFO_AW:0]   fifo_count
);
  localparam int BW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif
  state_t              state_q;
  logic [7:0]          mem_q [FIFO_DEPTH];
  logic [FIFO_AW-1:0]  wr_q, wr_d, rd_q, rd_d;
  logic [FIFO_AW:0]    cnt_q, cnt_d;
  logic [BW-1:0]       baud_q;
  logic [2:0]          bit_q;
  logic [7:0]          shift_q;
  logic                tx_q;
`ifdef UART_TX_PARITY_EN
  logic                par_q;
`endif
  logic                push, pop, baud_end;
  assign baud_end   = baud_q == BW'(CLK_DIV - 1);
  assign in_ready   = cnt_q != (FIFO_AW + 1)'(FIFO_DEPTH);
  assign push       = in_valid & in_ready;
  // The head byte leaves either from IDLE or at the last cycle of STOP, giving gap-free frames.
  assign pop        = (cnt_q != '0) & ((state_q == IDLE) | ((state_q == STOP) & baud_end));
  assign tx         = tx_q;
  assign busy       = (state_q != IDLE) | (cnt_q != '0);
  assign fifo_count = cnt_q;
  always_comb begin
    wr_d  = push ? wr_q + FIFO_AW'(1) : wr_q;
    rd_d  = pop ? rd_q + FIFO_AW'(1) : rd_q;
    cnt_d = cnt_q + {{FIFO_AW{1'b0}}, push} - {{FIFO_AW{1'b0}}, pop};
  end
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_q] <= in_data;
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
      baud_q <= (state_q == IDLE || baud_end) ? '0 : baud_q + BW'(1);
      if (pop) begin
        state_q <= START;
        shift_q <= mem_q[rd_q];
        bit_q   <= '0;
        tx_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
        par_q   <= ^mem_q[rd_q];
`endif
      end else begin
        case (state_q)
          START: if (baud_end) begin
            state_q <= DATA;
            tx_q    <= shift_q[0];
            shift_q <= shift_q >> 1;
            bit_q   <= '0;
          end
          DATA: if (baud_end) begin
            if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state_q <= PAR;
              tx_q    <= par_q;
`else
              state_q <= STOP;
              tx_q    <= 1'b1;
`endif
            end else begin
              bit_q   <= bit_q + 3'd1;
              tx_q    <= shift_q[0];
              shift_q <= shift_q >> 1;
            end
          end
`ifdef UART_TX_PARITY_EN
          PAR: if (baud_end) begin
            state_q <= STOP;
            tx_q    <= 1'b1;
          end
`endif
          STOP: if (baud_end) begin
            state_q <= IDLE;
            tx_q    <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer: directed bench for the UART TX serializer, bit-exact frame timing.
module tb_uart_tx_serializer;
  localparam int CLK_DIV = 16;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready, tx, busy;
  logic [3:0] fifo_count;
  int tests = 0;
  int fails = 0;

  uart_tx_serializer #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(8), .FIFO_AW(3)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .tx(tx), .busy(busy), .fifo_count(fifo_count)
  );

  always #5 clock = ~clock;

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] d);
    @(negedge clock);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clock);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_fall(output int n);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (tx !== 1'b0 && n < 400);
    chk("tx_fall", tx, 0);
  endtask

  // Call at the negedge of the first start-bit cycle; returns at the negedge after the frame.
  task automatic check_frame(input logic [7:0] b, output logic last_busy);
    logic e, ok;
    last_busy = 1'b0;
    for (int k = 0; k < NB; k++) begin
      e  = (k == 0) ? 1'b0 : (k <= 8) ? b[k-1] : (k == NB - 1) ? 1'b1 : ^b;
      ok = 1'b1;
      for (int c = 0; c < CLK_DIV; c++) begin
        if (tx !== e) ok = 1'b0;
        if (k == NB - 1 && c == CLK_DIV - 1) last_busy = busy;
        @(negedge clock);
      end
      chk($sformatf("byte%02h_bit%0d", b, k), ok, 1);
    end
  endtask

  initial begin
    int n, wt, full_cnt;
    logic lb, saw_full, ok;
    saw_full = 1'b0;
    full_cnt = 0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_tx", tx, 1);
    chk("rst_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_count", fifo_count, 0);
    reset = 1'b1;
    @(negedge clock);
    chk("post_rst_tx", tx, 1);
    chk("post_rst_busy", busy, 0);

    push(8'h41);
    chk("single_count_push", fifo_count, 1);
    chk("single_busy_push", busy, 1);
    wait_fall(n);
    chk("single_latency", n, 2);
    chk("single_count_pop", fifo_count, 0);
    check_frame(8'h41, lb);
    chk("single_busy_last", lb, 1);
    chk("single_busy_end", busy, 0);
    chk("single_tx_idle", tx, 1);

    fork
      begin
        for (int i = 0; i < 10; i++) begin
          @(negedge clock);
          wt = 0;
          while (!in_ready && wt < 3000) begin
            saw_full = 1'b1;
            full_cnt = fifo_count;
            wt++;
            @(negedge clock);
          end
          in_data  = 8'(i);
          in_valid = 1'b1;
          @(posedge clock);
          #1 in_valid = 1'b0;
        end
      end
      begin
        wait_fall(n);
        for (int i = 0; i < 10; i++) check_frame(8'(i), lb);
      end
    join
    chk("fill_saw_full", saw_full, 1);
    chk("fill_full_count", full_cnt, 8);
    chk("fill_busy_end", busy, 0);
    chk("fill_count_end", fifo_count, 0);

    push(8'hA1);
    push(8'hB2);
    push(8'hC3);
    push(8'hD4);
    chk("simul_count_load", fifo_count, 3);
    wait_fall(n);
    chk("simul_fall_idx", n, 1);
    repeat (157) @(negedge clock);
    chk("simul_pre_count", fifo_count, 3);
    chk("simul_pre_tx", tx, 1);
    in_data  = 8'hE5;
    in_valid = 1'b1;
    @(posedge clock);
    #1 in_valid = 1'b0;
    chk("simul_post_count", fifo_count, 3);
    chk("simul_post_tx", tx, 0);
    @(negedge clock);
    check_frame(8'hB2, lb);
    check_frame(8'hC3, lb);
    check_frame(8'hD4, lb);
    check_frame(8'hE5, lb);
    chk("simul_busy_end", busy, 0);

    push(8'hFF);
    push(8'h11);
    push(8'h22);
    wait_fall(n);
    repeat (87) @(negedge clock);
    chk("mid_tx_data", tx, 1);
    chk("mid_count", fifo_count, 2);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_tx", tx, 1);
    chk("mid_rst_count", fifo_count, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", in_ready, 1);
    @(negedge clock);
    reset = 1'b1;
    ok = 1'b1;
    repeat (300) begin
      @(negedge clock);
      if (tx !== 1'b1 || busy !== 1'b0) ok = 1'b0;
    end
    chk("mid_quiet_after", ok, 1);

    push(8'h00);
    wait_fall(n);
    #2 reset = 1'b0;
    #1 chk("start_rst_tx", tx, 1);
    @(negedge clock);
    reset = 1'b1;
    push(8'h5A);
    wait_fall(n);
    chk("restart_latency", n, 2);
    check_frame(8'h5A, lb);
    chk("restart_busy_end", busy, 0);

`ifdef UART_TX_PARITY_EN
    push(8'h07);
    wait_fall(n);
    check_frame(8'h07, lb);
    chk("par07_busy_last", lb, 1);
    chk("par07_busy_end", busy, 0);
    push(8'h03);
    wait_fall(n);
    check_frame(8'h03, lb);
    chk("par03_busy_last", lb, 1);
    chk("par03_busy_end", busy, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
